// File: rtl/lw_stall_logic.sv
// Load-use hazard detector: stalls FD/PC for one cycle when the consumer in FD
// reads a register that the lw in DX has not produced yet; counts stall cycles.
module lw_stall_logic #(
  parameter logic [4:0] LW_OP = 5'b01000,
  parameter logic [4:0] SW_OP = 5'b00111,
  parameter int         CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  output logic             stallLW,
  input  logic [4:0]       opcodeA,
  input  logic [4:0]       opcodeB,
  input  logic [4:0]       alu_opcodeA,
  input  logic [4:0]       alu_opcodeB,
  input  logic [4:0]       a_write,
  input  logic [4:0]       b_read1,
  input  logic [4:0]       b_read2,
  input  logic             is_noop,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRA  = 5'b00101;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The ALU function of the producer never matters for the hazard.
  logic unusedAluA;
  assign unusedAluA = ^alu_opcodeA;

  logic usesRs;
  logic usesRt;
  logic aIsLw;
  logic destOk;
  logic hit1;
  logic hit2;

  always_comb begin
    usesRs = 1'b0;
    usesRt = 1'b0;
    case (opcodeB)
      OP_RTYPE: begin
        usesRs = 1'b1;
        // Shifts take their amount from the instruction, not from rt.
        usesRt = (alu_opcodeB != ALU_SLL) && (alu_opcodeB != ALU_SRA);
      end
      OP_ADDI: usesRs = 1'b1;
      LW_OP:   usesRs = 1'b1;
      SW_OP: begin
        usesRs = 1'b1;
        usesRt = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        usesRs = 1'b1;
        usesRt = 1'b1;
      end
      OP_JR:   usesRt = 1'b1;
      default: begin
        usesRs = 1'b0;
        usesRt = 1'b0;
      end
    endcase
  end

  assign aIsLw  = (opcodeA == LW_OP) && !is_noop;
  assign destOk = (a_write != 5'd0);
  assign hit1   = usesRs && (b_read1 == a_write);
  // Store data is forwarded MW->XM, so only the address base must wait.
  assign hit2   = usesRt && (b_read2 == a_write) && (opcodeB != SW_OP);

  assign stallLW = aIsLw && destOk && (hit1 || hit2);

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stallLW && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_lw_stall_logic.sv
// Bench for lw_stall_logic: directed vectors with literal expectations, a
// rule-level hazard model checked every cycle, and a narrow instance for saturation.
module tb_lw_stall_logic;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  opcodeA = '0, opcodeB = '0, alu_opcodeA = '0, alu_opcodeB = '0;
  logic [4:0]  a_write = '0, b_read1 = '0, b_read2 = '0;
  logic        is_noop = 1'b0;
  logic        stallLW, stallSmall;
  logic [31:0] stall_count;
  logic [2:0]  countSmall;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;
  bit sweepActive = 1'b0;
  logic [0:0] exp_q[$];
  longint expCnt = 0;
  longint expCntSmall = 0;

  lw_stall_logic dut (
    .clock(clock), .reset(reset), .stallLW(stallLW),
    .opcodeA(opcodeA), .opcodeB(opcodeB),
    .alu_opcodeA(alu_opcodeA), .alu_opcodeB(alu_opcodeB),
    .a_write(a_write), .b_read1(b_read1), .b_read2(b_read2),
    .is_noop(is_noop), .stall_count(stall_count)
  );

  lw_stall_logic #(.CNT_W(3)) dutSmall (
    .clock(clock), .reset(reset), .stallLW(stallSmall),
    .opcodeA(opcodeA), .opcodeB(opcodeB),
    .alu_opcodeA(alu_opcodeA), .alu_opcodeB(alu_opcodeB),
    .a_write(a_write), .b_read1(b_read1), .b_read2(b_read2),
    .is_noop(is_noop), .stall_count(countSmall)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Hazard rules written as opcode lists rather than decode logic.
  function automatic bit modelStall(input logic [4:0] opA, opB, aluB, aw, r1, r2,
                                    input logic noop);
    int rsUsers[6] = '{0, 5, 7, 8, 2, 6};
    int rtUsers[4] = '{2, 6, 4, 7};
    bit uses1 = 1'b0;
    bit uses2 = 1'b0;
    bit hit;
    foreach (rsUsers[i]) if (int'(opB) == rsUsers[i]) uses1 = 1'b1;
    foreach (rtUsers[i]) if (int'(opB) == rtUsers[i]) uses2 = 1'b1;
    if (opB == 5'd0 && aluB != 5'd4 && aluB != 5'd5) uses2 = 1'b1;
    hit = (uses1 && r1 == aw) || (uses2 && r2 == aw && opB != 5'd7);
    return (opA == 5'd8) && !noop && (aw != 5'd0) && hit;
  endfunction

  function automatic bit modelNow();
    return modelStall(opcodeA, opcodeB, alu_opcodeB, a_write, b_read1, b_read2, is_noop);
  endfunction

  // driver: apply one vector for one cycle, queue its literal expectation
  task automatic drive(input logic [4:0] opA, opB, aluB, aw, r1, r2,
                       input logic noop, input logic [0:0] expStall);
    opcodeA = opA; opcodeB = opB; alu_opcodeB = aluB;
    alu_opcodeA = 5'($urandom_range(0, 31));
    a_write = aw; b_read1 = r1; b_read2 = r2; is_noop = noop;
    exp_q.push_back(expStall);
    @(posedge clock); #1;
  endtask

  // scoreboard: every negedge, DUT vs model, queued literals vs DUT and model
  always @(negedge clock) begin
    if (checkEn && !sweepActive) begin
      logic [0:0] e;
      bit m;
      m = modelNow();
      check("stall_vs_model", longint'(stallLW), longint'(m));
      check("small_stall_vs_model", longint'(stallSmall), longint'(m));
      check("count_vs_model", longint'(stall_count), expCnt);
      check("small_count_vs_model", longint'(countSmall), expCntSmall);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("vector_stall", longint'(stallLW), longint'(e));
        check("model_pin", longint'(m), longint'(e));
      end
      if (reset) begin
        expCnt = 0;
        expCntSmall = 0;
      end else if (m) begin
        expCnt = expCnt + 1;
        expCntSmall = (expCntSmall == 7) ? 7 : expCntSmall + 1;
      end
    end
  end

  initial begin
    reset = 1'b1;
    @(posedge clock); #1;
    checkEn = 1'b1;
    check("reset_count", longint'(stall_count), 0);
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // basic lw -> R-type consumer and bubble suppression
    drive(5'd8, 5'd0, 5'd0, 5'd5, 5'd5, 5'd7, 1'b0, 1'b1);
    drive(5'd8, 5'd0, 5'd0, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
    // $0 destination never stalls
    drive(5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(5'd8, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(5'd8, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    // producer not a load
    for (int op = 0; op < 8; op++)
      drive(5'(op), 5'd0, 5'd0, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0);
    // store: data operand bypassed, base operand stalls
    drive(5'd8, 5'd7, 5'd0, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0);
    drive(5'd8, 5'd7, 5'd0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1);
    // shifts read rs only
    drive(5'd8, 5'd0, 5'd4, 5'd4, 5'd2, 5'd4, 1'b0, 1'b0);
    drive(5'd8, 5'd0, 5'd0, 5'd4, 5'd2, 5'd4, 1'b0, 1'b1);
    drive(5'd8, 5'd0, 5'd5, 5'd4, 5'd2, 5'd4, 1'b0, 1'b0);
    drive(5'd8, 5'd1, 5'd0, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0);
    // other consumers
    drive(5'd8, 5'd2,  5'd0, 5'd12, 5'd1,  5'd12, 1'b0, 1'b1);
    drive(5'd8, 5'd6,  5'd0, 5'd12, 5'd12, 5'd1,  1'b0, 1'b1);
    drive(5'd8, 5'd4,  5'd0, 5'd12, 5'd1,  5'd12, 1'b0, 1'b1);
    drive(5'd8, 5'd4,  5'd0, 5'd12, 5'd12, 5'd1,  1'b0, 1'b0);
    drive(5'd8, 5'd5,  5'd0, 5'd12, 5'd1,  5'd12, 1'b0, 1'b0);
    drive(5'd8, 5'd8,  5'd0, 5'd12, 5'd12, 5'd1,  1'b0, 1'b1);
    drive(5'd8, 5'd22, 5'd0, 5'd12, 5'd12, 5'd12, 1'b0, 1'b0);
    drive(5'd8, 5'd3,  5'd0, 5'd12, 5'd12, 5'd12, 1'b0, 1'b0);
    drive(5'd8, 5'd21, 5'd0, 5'd12, 5'd12, 5'd12, 1'b0, 1'b0);

    // counter: three stall cycles from reset
    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) drive(5'd8, 5'd0, 5'd0, 5'd5, 5'd5, 5'd7, 1'b0, 1'b1);
    check("count_after_3", longint'(stall_count), 3);
    // reset mid-stall clears the count but not the stall
    reset = 1'b1;
    drive(5'd8, 5'd0, 5'd0, 5'd5, 5'd5, 5'd7, 1'b0, 1'b1);
    reset = 1'b0;
    check("count_after_reset", longint'(stall_count), 0);
    repeat (9) drive(5'd8, 5'd0, 5'd0, 5'd5, 5'd5, 5'd7, 1'b0, 1'b1);
    check("count_after_9", longint'(stall_count), 9);
    check("small_saturated", longint'(countSmall), 7);
    drive(5'd8, 5'd0, 5'd0, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
    check("count_hold", longint'(stall_count), 9);

    // sweep with a_write=0: never stalls
    sweepActive = 1'b1;
    a_write = 5'd0;
    is_noop = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      b_read1 = (pass == 0) ? 5'd0 : 5'd31;
      b_read2 = (pass == 0) ? 5'd31 : 5'd0;
      for (int oa = 0; oa < 32; oa++)
        for (int ob = 0; ob < 32; ob++)
          for (int xa = 0; xa < 8; xa++)
            for (int xb = 0; xb < 8; xb++) begin
              opcodeA = 5'(oa); opcodeB = 5'(ob);
              alu_opcodeA = 5'(xa); alu_opcodeB = 5'(xb);
              #1;
              check("sweep_zero", longint'(stallLW), 0);
              check("sweep_model", longint'(stallLW), longint'(modelNow()));
            end
    end
    @(posedge clock); #1;
    sweepActive = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("count_after_sweep", longint'(stall_count), 9);
    drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    if (exp_q.size() != 0) check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lw_stall_logic.md
Name: lw_stall_logic

Overview:
- Load-use hazard detector for the 5-stage pipeline.
- Compares the instruction in DX (slot A, possible `lw`) with the instruction in FD (slot B, consumer).
- Asserts a combinational stall when B needs a register that A's load has not yet produced. PC/FD then freeze and a bubble is injected into DX.
- Also keeps a clocked stall-event counter for performance monitoring.

Parameters:
- LW_OP, 5'b01000, opcode of load word
- SW_OP, 5'b00111, opcode of store word
- CNT_W, 32, width of the stall counter

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high; clears the counter
- stallLW  out  1  combinational stall request
- opcodeA  in  5  opcode of instruction A (DX)
- opcodeB  in  5  opcode of instruction B (FD)
- alu_opcodeA  in  5  ALU function field of A; no effect on stallLW
- alu_opcodeB  in  5  ALU function field of B; used when opcodeB = 00000
- a_write  in  5  destination register of A
- b_read1  in  5  first source register (rs) of B
- b_read2  in  5  second source register (rt/rd) of B
- is_noop  in  1  A is a bubble/flushed slot
- stall_count  out  CNT_W  number of cycles stallLW was high since reset

Behaviour:
- Pure combinational path from inputs to stallLW; no clock dependency, zero latency.
- a_is_lw = (opcodeA == LW_OP) & ~is_noop.
- dest_ok = (a_write != 0); register $0 never causes a stall.
- B use of b_read1 (rs) for opcodeB in {00000 R-type, 00101 addi, 00111 sw, 01000 lw, 00010 bne, 00110 blt}.
- B use of b_read2:
  - For opcodeB in {00010 bne, 00110 blt, 00100 jr, 00111 sw}.
  - For opcodeB = 00000, only when alu_opcodeB is not 00100 (sll) and not 00101 (sra). Shifts read rs only.
- Opcodes j 00001, jal 00011, setx 10101, bex 10110 and every undefined opcode read neither port.
- hit1 = uses1 & (b_read1 == a_write).
- hit2 = uses2 & (b_read2 == a_write).
- Store exception: if opcodeB == SW_OP, hit2 is ignored, because store data is bypassed MW->XM. hit1 (address base) still stalls.
- stallLW = a_is_lw & dest_ok & (hit1 | hit2).
- X-free: any defined input combination yields a defined 0/1 output.
- Counter:
  - On rising clock: reset=1 -> stall_count <= 0.
  - Else if stallLW -> stall_count+1, saturating at all-ones (no wrap).
  - Else holds.
  - Reset mid-stall clears the counter that cycle; stallLW itself is unaffected by reset.
- Reset value: stall_count = 0. stallLW has no reset value and always reflects its current inputs.
- Single-cycle stall property: after a stall, the pipeline drives is_noop=1 for DX, so stallLW drops the next cycle with no internal state.

Test Plan:
- opcodeA=01000, a_write=5, opcodeB=00000, alu_opcodeB=00000, b_read1=5, b_read2=7, is_noop=0 -> stallLW=1. Same with is_noop=1 -> stallLW=0.
- opcodeA=01000, a_write=0, b_read1=0, b_read2=0, any opcodeB -> stallLW=0. opcodeA=00000..00111 with all register fields equal -> stallLW=0.
- opcodeA=01000, a_write=9, opcodeB=00111 (sw):
  - b_read2=9, b_read1=3 -> stallLW=0.
  - b_read1=9 -> stallLW=1.
- opcodeA=01000, a_write=4, opcodeB=00000:
  - alu_opcodeB=00100 (sll), b_read2=4, b_read1=2 -> stallLW=0.
  - alu_opcodeB=00000 -> stallLW=1.
  - opcodeB=00001 (j) with b_read1=4 -> stallLW=0.
- Exhaustive sweep of opcodeA, opcodeB, alu_opcodeA and alu_opcodeB lower 3 bits, with b_read1=0/b_read2=31 and then inverted, a_write=0 -> stallLW never 1; compare against the reference equation.
- Counter:
  - Hold a stall condition for 3 cycles -> stall_count=3.
  - Assert reset for 1 cycle -> 0.
  - Preload near max (force) -> saturates at 2^CNT_W-1.
